// File: rtl/heaviside.sv
// Unit-step activation stage.
// Forward: signed Q8.8 argument -> 0xFF when non-negative, 0x00 when negative.
// Backward: error passed straight through as feedback while training is enabled.
// Each path is an independent single-entry output register with stb/rdy handshakes.
module heaviside (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  // Forward argument
  input  logic        arg_stb,
  output logic        arg_rdy,
  input  logic [15:0] arg_dat,
  // Forward result
  output logic        res_stb,
  input  logic        res_rdy,
  output logic [7:0]  res_dat,
  // Backward error
  input  logic        err_stb,
  output logic        err_rdy,
  input  logic [15:0] err_dat,
  // Backward feedback
  output logic        fbk_stb,
  input  logic        fbk_rdy,
  output logic [15:0] fbk_dat
);

  typedef enum logic {
    StIdle,
    StFull
  } slot_state_e;

  slot_state_e fwd_state;
  slot_state_e bwd_state;

  logic arg_take;
  logic err_take;

  // Ready depends only on registered state, so there is no rdy-to-rdy comb path.
  always_comb begin
    arg_rdy  = (fwd_state == StIdle);
    err_rdy  = en && (bwd_state == StIdle);
    arg_take = arg_stb && arg_rdy;
    err_take = err_stb && err_rdy;
  end

  // Forward slot: load step value on accept, hold until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_state <= StIdle;
      res_stb   <= 1'b0;
      res_dat   <= 8'h00;
    end else begin
      unique case (fwd_state)
        StIdle: begin
          if (arg_take) begin
            fwd_state <= StFull;
            res_stb   <= 1'b1;
            // Zero is non-negative, so only the sign bit matters.
            res_dat   <= arg_dat[15] ? 8'h00 : 8'hFF;
          end
        end
        StFull: begin
          if (res_rdy) begin
            fwd_state <= StIdle;
            res_stb   <= 1'b0;
          end
        end
        default: begin
          fwd_state <= StIdle;
          res_stb   <= 1'b0;
        end
      endcase
    end
  end

  // Backward slot: straight-through copy of the error. A pending feedback is
  // delivered even if en drops, since en only gates acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      bwd_state <= StIdle;
      fbk_stb   <= 1'b0;
      fbk_dat   <= 16'h0000;
    end else begin
      unique case (bwd_state)
        StIdle: begin
          if (err_take) begin
            bwd_state <= StFull;
            fbk_stb   <= 1'b1;
            fbk_dat   <= err_dat;
          end
        end
        StFull: begin
          if (fbk_rdy) begin
            bwd_state <= StIdle;
            fbk_stb   <= 1'b0;
          end
        end
        default: begin
          bwd_state <= StIdle;
          fbk_stb   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_heaviside.sv
// Directed bench for the heaviside activation stage.
module tb_heaviside;

  logic        clk;
  logic        rst;
  logic        en;
  logic        arg_stb;
  logic        arg_rdy;
  logic [15:0] arg_dat;
  logic        res_stb;
  logic        res_rdy;
  logic [7:0]  res_dat;
  logic        err_stb;
  logic        err_rdy;
  logic [15:0] err_dat;
  logic        fbk_stb;
  logic        fbk_rdy;
  logic [15:0] fbk_dat;

  int checks;
  int failures;

  heaviside dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .arg_stb (arg_stb),
    .arg_rdy (arg_rdy),
    .arg_dat (arg_dat),
    .res_stb (res_stb),
    .res_rdy (res_rdy),
    .res_dat (res_dat),
    .err_stb (err_stb),
    .err_rdy (err_rdy),
    .err_dat (err_dat),
    .fbk_stb (fbk_stb),
    .fbk_rdy (fbk_rdy),
    .fbk_dat (fbk_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full forward transaction with an immediate downstream accept.
  task automatic fwd_xfer(input string tag, input logic [15:0] a, input logic [7:0] exp);
    arg_stb = 1'b1;
    arg_dat = a;
    #1;
    check_eq({tag, "_rdy"}, 32'(arg_rdy), 32'd1);
    tick();
    arg_stb = 1'b0;
    arg_dat = 16'($urandom);
    check_eq({tag, "_stb"}, 32'(res_stb), 32'd1);
    check_eq({tag, "_dat"}, 32'(res_dat), 32'(exp));
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    check_eq({tag, "_done"}, 32'(res_stb), 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    arg_stb  = 1'b0;
    arg_dat  = 16'h0000;
    res_rdy  = 1'b0;
    err_stb  = 1'b0;
    err_dat  = 16'h0000;
    fbk_rdy  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst_res_stb", 32'(res_stb), 32'd0);
    check_eq("rst_fbk_stb", 32'(fbk_stb), 32'd0);
    check_eq("rst_res_dat", 32'(res_dat), 32'h00);
    check_eq("rst_fbk_dat", 32'(fbk_dat), 32'h0000);
    check_eq("rst_arg_rdy", 32'(arg_rdy), 32'd1);
    check_eq("rst_err_rdy", 32'(err_rdy), 32'd0);

    // Zero argument, result held until res_rdy
    arg_stb = 1'b1;
    arg_dat = 16'h0000;
    tick();
    arg_stb = 1'b0;
    arg_dat = 16'h8000;
    check_eq("zero_stb", 32'(res_stb), 32'd1);
    check_eq("zero_dat", 32'(res_dat), 32'hFF);
    check_eq("zero_rdy_low", 32'(arg_rdy), 32'd0);
    tick();
    tick();
    check_eq("zero_held_stb", 32'(res_stb), 32'd1);
    check_eq("zero_held_dat", 32'(res_dat), 32'hFF);
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    check_eq("zero_done_stb", 32'(res_stb), 32'd0);
    check_eq("zero_rdy_back", 32'(arg_rdy), 32'd1);

    // en=1, -1 forward and backward
    en = 1'b1;
    #1;
    check_eq("en_err_rdy", 32'(err_rdy), 32'd1);
    fwd_xfer("neg1", 16'hFFFF, 8'h00);
    err_stb = 1'b1;
    err_dat = 16'hFFFF;
    tick();
    err_stb = 1'b0;
    err_dat = 16'h0000;
    check_eq("fbk_neg1_stb", 32'(fbk_stb), 32'd1);
    check_eq("fbk_neg1_dat", 32'(fbk_dat), 32'hFFFF);
    check_eq("fbk_neg1_err_rdy", 32'(err_rdy), 32'd0);
    fbk_rdy = 1'b1;
    tick();
    fbk_rdy = 1'b0;
    check_eq("fbk_neg1_done", 32'(fbk_stb), 32'd0);

    // Boundary arguments
    fwd_xfer("b7fff", 16'h7FFF, 8'hFF);
    fwd_xfer("b0001", 16'h0001, 8'hFF);

    // 0x8000 with a stalled consumer; a competing non-negative argument must be ignored
    arg_stb = 1'b1;
    arg_dat = 16'h8000;
    tick();
    arg_dat = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_arg_rdy", 32'(arg_rdy), 32'd0);
      check_eq("stall_res_stb", 32'(res_stb), 32'd1);
      check_eq("stall_res_dat", 32'(res_dat), 32'h00);
      tick();
    end
    arg_stb = 1'b0;
    res_rdy = 1'b1;
    tick();
    res_rdy = 1'b0;
    check_eq("stall_done", 32'(res_stb), 32'd0);

    // en=0 blocks errors
    en      = 1'b0;
    err_stb = 1'b1;
    err_dat = 16'h5A5A;
    #1;
    for (int i = 0; i < 10; i++) begin
      check_eq("noen_err_rdy", 32'(err_rdy), 32'd0);
      check_eq("noen_fbk_stb", 32'(fbk_stb), 32'd0);
      tick();
    end
    en = 1'b1;
    #1;
    check_eq("reen_err_rdy", 32'(err_rdy), 32'd1);
    tick();
    err_stb = 1'b0;
    err_dat = 16'h0000;
    check_eq("reen_fbk_stb", 32'(fbk_stb), 32'd1);
    check_eq("reen_fbk_dat", 32'(fbk_dat), 32'h5A5A);

    // Dropping en while FULL keeps the pending feedback
    en = 1'b0;
    tick();
    tick();
    check_eq("drop_en_stb", 32'(fbk_stb), 32'd1);
    check_eq("drop_en_dat", 32'(fbk_dat), 32'h5A5A);
    fbk_rdy = 1'b1;
    tick();
    fbk_rdy = 1'b0;
    check_eq("drop_en_done", 32'(fbk_stb), 32'd0);

    // Simultaneous forward and backward
    en      = 1'b1;
    res_rdy = 1'b1;
    fbk_rdy = 1'b1;
    arg_stb = 1'b1;
    arg_dat = 16'h0100;
    err_stb = 1'b1;
    err_dat = 16'h1234;
    tick();
    arg_stb = 1'b0;
    err_stb = 1'b0;
    res_rdy = 1'b0;
    fbk_rdy = 1'b0;
    check_eq("sim_res_stb", 32'(res_stb), 32'd1);
    check_eq("sim_res_dat", 32'(res_dat), 32'hFF);
    check_eq("sim_fbk_stb", 32'(fbk_stb), 32'd1);
    check_eq("sim_fbk_dat", 32'(fbk_dat), 32'h1234);
    tick();
    check_eq("sim_hold_res", 32'(res_stb), 32'd1);
    check_eq("sim_hold_fbk", 32'(fbk_stb), 32'd1);

    // Reset while both slots are FULL, with new inputs offered on the same edge
    rst     = 1'b1;
    arg_stb = 1'b1;
    arg_dat = 16'h0000;
    err_stb = 1'b1;
    err_dat = 16'hBEEF;
    tick();
    rst     = 1'b0;
    arg_stb = 1'b0;
    err_stb = 1'b0;
    #1;
    check_eq("mrst_res_stb", 32'(res_stb), 32'd0);
    check_eq("mrst_fbk_stb", 32'(fbk_stb), 32'd0);
    check_eq("mrst_res_dat", 32'(res_dat), 32'h00);
    check_eq("mrst_fbk_dat", 32'(fbk_dat), 32'h0000);
    check_eq("mrst_arg_rdy", 32'(arg_rdy), 32'd1);
    check_eq("mrst_err_rdy", 32'(err_rdy), 32'd1);
    tick();
    check_eq("mrst_stay_res", 32'(res_stb), 32'd0);
    check_eq("mrst_stay_fbk", 32'(fbk_stb), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
